// File: rtl/dma_pkg.sv
// Shared definitions for the DMA register block: register offsets, AHB encodings
// and the CTRL register layout.
package dma_pkg;

  localparam logic [8:0] DMA_SRC_OFS    = 9'h000;
  localparam logic [8:0] DMA_DST_OFS    = 9'h004;
  localparam logic [8:0] DMA_LEN_OFS    = 9'h008;
  localparam logic [8:0] DMA_CTRL_OFS   = 9'h00C;
  localparam logic [8:0] DMA_STATUS_OFS = 9'h100;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef struct packed {
    logic irq_en;
    logic start;
  } dma_ctrl_t;

endpackage

// File: rtl/dma_ahb_ch_regs.sv
// One DMA channel's SRC/DST/LEN/CTRL registers, the busy write-lock checks and the
// registered start pulse.
module dma_ahb_ch_regs
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 busy,
  input  logic                 a_sel,
  input  logic                 a_write,
  input  logic [1:0]           a_reg,
  output logic                 a_lock,
  input  logic                 d_sel,
  input  logic                 d_write,
  input  logic [1:0]           d_reg,
  input  logic [31:0]          wdata,
  input  logic                 commit,
  output logic                 d_lock,
  output logic [31:0]          rdata,
  output logic                 start,
  output logic [31:0]          src,
  output logic [31:0]          dst,
  output logic [LEN_WIDTH-1:0] len,
  output logic                 irq_en
);

  localparam logic [1:0] R_SRC  = DMA_SRC_OFS[3:2];
  localparam logic [1:0] R_DST  = DMA_DST_OFS[3:2];
  localparam logic [1:0] R_LEN  = DMA_LEN_OFS[3:2];
  localparam logic [1:0] R_CTRL = DMA_CTRL_OFS[3:2];

  dma_ctrl_t wctrl;
  logic      wr;

  assign wctrl  = dma_ctrl_t'(wdata[1:0]);
  // SRC/DST/LEN locks are known from the address; a CTRL START lock needs the write data.
  assign a_lock = a_sel & a_write & busy & (a_reg != R_CTRL);
  assign d_lock = d_sel & d_write & busy & (d_reg == R_CTRL) & wctrl.start;
  assign wr     = d_sel & d_write & commit;

  // NOTE: every flop here is a plain register with an async reset; state is updated with
  // non-blocking assignments so all registers see pre-edge values within the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      irq_en <= 1'b0;
      start  <= 1'b0;
    end else begin
      start <= wr & (d_reg == R_CTRL) & wctrl.start;
      if (wr) begin
        case (d_reg)
          R_SRC:   src    <= wdata;
          R_DST:   dst    <= wdata;
          R_LEN:   len    <= wdata[LEN_WIDTH-1:0];
          default: irq_en <= wctrl.irq_en;
        endcase
      end
    end
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    rdata = '0;
    case (d_reg)
      R_SRC:   rdata = src;
      R_DST:   rdata = dst;
      R_LEN:   rdata = 32'(len);
      default: rdata = {30'b0, irq_en, 1'b0};
    endcase
  end

endmodule

// File: rtl/dma_ahb_regs.sv
// AHB-Lite subordinate for the DMA register file: transfer FSM, address decode,
// STATUS done bits and the interrupt.
module dma_ahb_regs
  import dma_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hsel,
  input  logic [ADDR_WIDTH-1:0]       haddr,
  input  logic [1:0]                  htrans,
  input  logic                        hwrite,
  input  logic [2:0]                  hsize,
  input  logic [DATA_WIDTH-1:0]       hwdata,
  input  logic                        hreadyin,
  output logic                        hreadyout,
  output logic                        hresp,
  output logic [DATA_WIDTH-1:0]       hrdata,
  input  logic [NUM_CH-1:0]           ch_busy,
  input  logic [NUM_CH-1:0]           ch_done,
  output logic [NUM_CH-1:0]           ch_start,
  output logic [NUM_CH*32-1:0]        ch_src,
  output logic [NUM_CH*32-1:0]        ch_dst,
  output logic [NUM_CH*LEN_WIDTH-1:0] ch_len,
  output logic                        irq
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state, state_nx;
  logic                  accept, legal, size_ok, is_status, late_err, commit;
  logic [NUM_CH-1:0]     a_sel, a_lock, d_sel, d_lock, irq_en, done_q, done_clr;
  logic                  cap_write, cap_status, irq_q;
  logic [1:0]            cap_reg;
  logic [31:0]           ch_rdata [NUM_CH];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_addr;

  assign unused_addr = ^haddr[ADDR_WIDTH-1:9];

  assign accept    = hsel & hreadyin & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign size_ok   = (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00);
  assign is_status = (haddr[8:2] == DMA_STATUS_OFS[8:2]);
  assign legal     = size_ok & (is_status | (|a_sel)) & ~(|a_lock);
  assign late_err  = (state == S_DATA) & (|d_lock);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign a_sel[n] = ~haddr[8] & (haddr[7:4] == 4'(n));

    dma_ahb_ch_regs #(.LEN_WIDTH(LEN_WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .busy    (ch_busy[n]),
      .a_sel   (a_sel[n]),
      .a_write (hwrite),
      .a_reg   (haddr[3:2]),
      .a_lock  (a_lock[n]),
      .d_sel   (d_sel[n]),
      .d_write (cap_write),
      .d_reg   (cap_reg),
      .wdata   (hwdata),
      .commit  (commit),
      .d_lock  (d_lock[n]),
      .rdata   (ch_rdata[n]),
      .start   (ch_start[n]),
      .src     (ch_src[n*32 +: 32]),
      .dst     (ch_dst[n*32 +: 32]),
      .len     (ch_len[n*LEN_WIDTH +: LEN_WIDTH]),
      .irq_en  (irq_en[n])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // A CTRL START-while-busy write is only detectable from hwdata, so the DATA cycle
  // itself plays the first error cycle and the FSM moves straight to ERR2.
  always_comb begin
    state_nx  = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    commit    = 1'b0;
    case (state)
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nx  = S_ERR2;
      end
      S_DATA: begin
        if (late_err) begin
          hreadyout = 1'b0;
          hresp     = 1'b1;
          state_nx  = S_ERR2;
        end else begin
          commit   = 1'b1;
          state_nx = accept ? (legal ? S_DATA : S_ERR1) : S_IDLE;
        end
      end
      S_ERR2: begin
        hresp    = 1'b1;
        state_nx = accept ? (legal ? S_DATA : S_ERR1) : S_IDLE;
      end
      default: state_nx = accept ? (legal ? S_DATA : S_ERR1) : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_write  <= 1'b0;
      cap_status <= 1'b0;
      cap_reg    <= '0;
      d_sel      <= '0;
    end else if (state_nx == S_DATA) begin
      cap_write  <= hwrite;
      cap_status <= is_status;
      cap_reg    <= haddr[3:2];
      d_sel      <= a_sel;
    end
  end

  assign done_clr = (commit & cap_write & cap_status) ? hwdata[NUM_CH-1:0] : '0;

  // Clear is applied before set, so a coincident ch_done keeps the bit high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      done_q <= (done_q & ~done_clr) | ch_done;
      irq_q  <= |(done_q & irq_en);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (cap_status) rd_mux = DATA_WIDTH'(done_q) | (DATA_WIDTH'(ch_busy) << 8);
    for (int n = 0; n < NUM_CH; n++) begin
      if (d_sel[n]) rd_mux = rd_mux | ch_rdata[n];
    end
  end

  assign hrdata = (state == S_DATA) ? rd_mux : '0;
  assign irq    = irq_q;

endmodule

// File: tb/tb_dma_ahb_regs.sv
// Randomized bench for dma_ahb_regs against a register-map level reference model.
module tb_dma_ahb_regs;

  localparam int NUM_CH = 4;
  localparam int LW     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hreadyin;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_start;
  logic [NUM_CH*32-1:0] ch_src;
  logic [NUM_CH*32-1:0] ch_dst;
  logic [NUM_CH*LW-1:0] ch_len;
  logic              irq;

  // Single-subordinate bus: the interconnect HREADY is our own hreadyout.
  assign hreadyin = hreadyout;

  always #5 clk = ~clk;

  dma_ahb_regs #(.NUM_CH(NUM_CH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .ch_busy(ch_busy), .ch_done(ch_done),
    .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the register map as plain arrays.
  logic [31:0]       m_src [NUM_CH];
  logic [31:0]       m_dst [NUM_CH];
  logic [LW-1:0]     m_len [NUM_CH];
  logic              m_ien [NUM_CH];
  logic [NUM_CH-1:0] m_done;
  logic [NUM_CH-1:0] exp_start;

  function automatic void m_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_src[i] = '0; m_dst[i] = '0; m_len[i] = '0; m_ien[i] = 1'b0;
    end
    m_done = '0;
  endfunction

  function automatic bit m_legal(logic wr, logic [31:0] addr, logic [2:0] size, logic [31:0] data);
    int off = int'(addr % 512);
    int ch  = off / 16;
    int r   = (off % 16) / 4;
    if (size != 3'd2 || (addr % 4) != 0) return 1'b0;
    if (off == 256) return 1'b1;
    if (off > 255 || ch >= NUM_CH) return 1'b0;
    if (wr && ch_busy[ch] && (r != 3 || data[0])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] addr);
    int off = int'(addr % 512);
    int ch  = off / 16;
    int r   = (off % 16) / 4;
    if (off == 256) return {20'b0, ch_busy, 4'b0, m_done};
    case (r)
      0:       return m_src[ch];
      1:       return m_dst[ch];
      2:       return {16'b0, m_len[ch]};
      default: return {30'b0, m_ien[ch], 1'b0};
    endcase
  endfunction

  function automatic void m_write(logic [31:0] addr, logic [31:0] data);
    int off = int'(addr % 512);
    int ch  = off / 16;
    int r   = (off % 16) / 4;
    if (off == 256) begin
      m_done = m_done & ~data[NUM_CH-1:0];
    end else begin
      case (r)
        0:       m_src[ch] = data;
        1:       m_dst[ch] = data;
        2:       m_len[ch] = data[LW-1:0];
        default: begin
          m_ien[ch] = data[1];
          if (data[0]) exp_start[ch] = 1'b1;
        end
      endcase
    end
  endfunction

  function automatic logic [127:0] f_src();
    logic [127:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*32 +: 32] = m_src[i];
    return v;
  endfunction

  function automatic logic [127:0] f_dst();
    logic [127:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*32 +: 32] = m_dst[i];
    return v;
  endfunction

  function automatic logic [127:0] f_len();
    logic [127:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*LW +: LW] = m_len[i];
    return v;
  endfunction

  function automatic logic m_irq();
    logic v = 1'b0;
    for (int i = 0; i < NUM_CH; i++) v = v | (m_done[i] & m_ien[i]);
    return v;
  endfunction

  // One NONSEQ transfer; 'pulse' is driven on ch_done so it lands on the commit edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] data, input logic [NUM_CH-1:0] pulse,
                      output logic fr, output logic s1, output logic r2, output logic s2,
                      output logic [NUM_CH-1:0] st2, output logic [31:0] rd);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = data; ch_done = pulse;
    @(negedge clk);
    fr = hreadyout; s1 = hresp; rd = hrdata;
    @(posedge clk); #1;
    ch_done = '0;
    r2 = 1'b1; s2 = 1'b0; st2 = '0;
    if (!fr) begin
      @(negedge clk);
      r2 = hreadyout; s2 = hresp; st2 = ch_start;
    end
  endtask

  task automatic bus_op(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] data, input logic [NUM_CH-1:0] pulse,
                        output logic [31:0] rd);
    logic ok, fr, s1, r2, s2;
    logic [NUM_CH-1:0] st2;
    logic [31:0] exp_rd;
    ok = m_legal(wr, addr, size, data);
    exp_rd = m_read(addr);
    exp_start = '0;
    xfer(wr, addr, size, data, pulse, fr, s1, r2, s2, st2, rd);
    if (ok) begin
      check("okay_ready", fr, 1'b1);
      check("okay_resp", s1, 1'b0);
      if (!wr) check("rdata", rd, exp_rd);
      if (wr) m_write(addr, data);
    end else begin
      check("err1_ready", fr, 1'b0);
      check("err1_resp", s1, 1'b1);
      check("err2_ready", r2, 1'b1);
      check("err2_resp", s2, 1'b1);
      check("err_no_start", st2, '0);
    end
    m_done = m_done | pulse;
    @(negedge clk);
    check("start", ch_start, exp_start);
    check("src", ch_src, f_src());
    check("dst", ch_dst, f_dst());
    check("len", ch_len, f_len());
    @(negedge clk);
    check("start_off", ch_start, '0);
    check("irq", irq, m_irq());
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, addr, data;
    logic [2:0]  size;
    logic        wr;
    logic [NUM_CH-1:0] pulse;

    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hwdata = '0; ch_busy = '0; ch_done = '0; exp_start = '0;
    m_clear();
    repeat (2) @(negedge clk);
    check("rst_hready", hreadyout, 1'b1);
    check("rst_hresp", hresp, 1'b0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_start", ch_start, '0);
    check("rst_irq", irq, 1'b0);
    check("rst_src", ch_src, '0);
    rst = 1'b0;
    @(negedge clk);

    // SRC0 write and readback
    bus_op(1'b1, 32'h000, 3'd2, 32'h1000_0000, '0, rd);
    bus_op(1'b0, 32'h000, 3'd2, 32'h0, '0, rd);
    check("t1_rdata", rd, 32'h1000_0000);
    check("t1_src0", ch_src[31:0], 32'h1000_0000);

    // CTRL start + IRQ_EN
    bus_op(1'b1, 32'h00C, 3'd2, 32'h3, '0, rd);
    bus_op(1'b0, 32'h00C, 3'd2, 32'h0, '0, rd);
    check("t2_ctrl_rd", rd, 32'h2);

    // done -> irq, W1C, coincident set/clear
    bus_op(1'b0, 32'h100, 3'd2, 32'h0, 4'b0001, rd);
    check("t3_irq_set", irq, 1'b1);
    bus_op(1'b0, 32'h100, 3'd2, 32'h0, '0, rd);
    check("t3_status", rd[3:0], 4'b0001);
    bus_op(1'b1, 32'h100, 3'd2, 32'h1, '0, rd);
    check("t3_irq_clr", irq, 1'b0);
    bus_op(1'b1, 32'h100, 3'd2, 32'h1, 4'b0001, rd);
    bus_op(1'b0, 32'h100, 3'd2, 32'h0, '0, rd);
    check("t3_coinc", rd[0], 1'b1);

    // unmapped channel
    bus_op(1'b1, 32'h0F0, 3'd2, 32'hDEAD_BEEF, '0, rd);
    bus_op(1'b0, 32'h0F0, 3'd2, 32'h0, '0, rd);

    // busy locks and bad size
    ch_busy = 4'b0010;
    bus_op(1'b1, 32'h014, 3'd2, 32'h5555_0000, '0, rd);
    bus_op(1'b1, 32'h01C, 3'd2, 32'h1, '0, rd);
    bus_op(1'b1, 32'h01C, 3'd2, 32'h2, '0, rd);
    ch_busy = '0;
    bus_op(1'b0, 32'h014, 3'd2, 32'h0, '0, rd);
    check("t5_dst1", rd, 32'h0);
    bus_op(1'b1, 32'h000, 3'd0, 32'hFF, '0, rd);
    check("t5_src0", ch_src[31:0], 32'h1000_0000);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      int cat = $urandom_range(0, 9);
      int ch  = $urandom_range(0, NUM_CH);
      int r   = $urandom_range(0, 3);
      if (cat <= 6)      addr = 32'(ch * 16 + r * 4);
      else if (cat == 7) addr = 32'h100;
      else if (cat == 8) addr = 32'(260 + 4 * $urandom_range(0, 62));
      else               addr = 32'(ch * 16 + r * 4 + $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_FE00);
      size    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 2)) : 3'd2;
      wr      = 1'($urandom_range(0, 1));
      data    = $urandom;
      pulse   = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
      ch_busy = ($urandom_range(0, 2) == 0) ? NUM_CH'($urandom) : '0;
      bus_op(wr, addr, size, data, pulse, rd);
    end
    ch_busy = '0;

    // back-to-back write then read of SRC2
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h020; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'hA5A5_1234; hwrite = 1'b0;
    @(negedge clk);
    check("t6_wr_ready", hreadyout, 1'b1);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    check("t6_raw", hrdata, 32'hA5A5_1234);
    check("t6_raw_resp", hresp, 1'b0);

    // reset asserted during a write data phase
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h000; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_hready", hreadyout, 1'b1);
    check("t6_rst_hresp", hresp, 1'b0);
    check("t6_rst_hrdata", hrdata, 32'h0);
    check("t6_rst_start", ch_start, '0);
    check("t6_rst_irq", irq, 1'b0);
    check("t6_rst_src", ch_src, '0);
    check("t6_rst_dst", ch_dst, '0);
    check("t6_rst_len", ch_len, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    @(negedge clk);
    bus_op(1'b0, 32'h000, 3'd2, 32'h0, '0, rd);
    check("t6_no_partial_write", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
